jtframe_lfbuf_memctl: RTL and testbench
=======================================

// Module: jtframe_lfbuf_memctl
// PURPOSE
// - SDRAM-side sequencer for the line-based frame buffer. Each new core line
//   (ln_hs) dumps the previously drawn line buffer half to SDRAM, then clears it.
// - At each H-blank start, reads the next display row of the other frame page
//   from SDRAM into the screen line buffer (rd_addr/fb_dout/scr_we).
// - Sits between the line-buffer stage (fb_*, line, scr_we) and the SDRAM port.
// PARAMETERS
// - VW   8       row address width
// - HW   9       column address width
// - HMAX 9'd255  last column transferred per line (width HW)
// PORTS
// - clk      in   1        clock
// - rst      in   1        reset, asynchronous, active-high
// - vrender  in   VW       row being prepared for display
// - lhbl     in   1        horizontal blank, active low
// - lvbl     in   1        vertical blank, active low
// - frame    in   1        page currently written by the core
// - ln_hs    in   1        1-cycle pulse: core starts drawing row ln_v
// - ln_v     in   VW       row the core is drawing
// - fb_addr  out  HW       line-buffer address for dump/clear
// - fb_din   in   16       line-buffer data, valid 1 cycle after fb_addr
// - fb_clr   out  1        clear strobe for the line-buffer half at fb_addr
// - fb_done  out  1        1-cycle pulse: dump+clear finished
// - line     out  1        line-buffer half select, toggles per accepted ln_hs
// - rd_addr  out  HW       screen-buffer write address
// - fb_dout  out  16       screen-buffer write data
// - scr_we   out  1        screen-buffer write strobe
// - mem_addr out  VW+HW+1  word address {page,row,col}
// - mem_rd   out  1        read request, held until mem_ack
// - mem_wr   out  1        write request, held until mem_ack
// - mem_din  out  16       write data to SDRAM
// - mem_dout in   16       read data, valid with mem_ack
// - mem_ack  in   1        1-cycle per-word completion
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; pend_rd=pend_wr=0; first=1; dump row 0.
// - Events: lhbl falling edge sets pend_rd; ln_hs toggles line and sets
//   pend_wr next cycle. If ln_hs arrives while pend_wr=1, it is dropped.
// - Page toggle: a change of frame sets first=1.
// - IDLE: pend_rd has priority over pend_wr; a new request starts the cycle
//   after it is set.
// - READ: for col 0..HMAX, mem_rd=1, mem_addr={~frame,vrender,col}.
//   On mem_ack: fb_dout<=mem_dout, rd_addr<=col, scr_we=1 for one cycle.
//   After HMAX, clear pend_rd and go to IDLE.
// - WRITE: skipped when first=1. For col 0..HMAX: fb_addr<=col, wait 1 cycle,
//   then mem_wr=1 with mem_din=fb_din and mem_addr={frame,row_l,col} until
//   mem_ack. row_l is ln_v latched at the previous accepted ln_hs.
// - CLR: fb_clr=1, fb_addr 0..HMAX, one word per cycle (HMAX+1 cycles).
// - DONE: fb_done=1 for 1 cycle. Clear pend_wr and first, latch row_l<=ln_v,
//   go to IDLE.
// - A READ request arriving mid-WRITE/CLR waits; READ never preempts a word
//   in flight. Column counters stop at HMAX (no wrap).
// - mem_rd and mem_wr are never high together. Requests hold address/data stable.
// - Reset mid-transfer aborts immediately; requests drop in the same cycle.
// CONFIGURATION
// - JTFRAME_LFBUF_VBSKIP_EN defined: pend_rd is not set while lvbl=0, so
//   there are no SDRAM reads during V-blank and the bandwidth goes to dumps.
// - Not defined: a read occurs on every lhbl falling edge.
// TESTING
// - Reset, mem_ack tied to 1 cycle latency -> all outputs 0.
//   lhbl fall -> 256 scr_we pulses, rd_addr 0..255, mem_addr page=~frame.
// - First ln_hs after a frame change, ln_v=16 -> line toggles, no mem_wr,
//   256 fb_clr cycles, then one fb_done pulse.
// - Second ln_hs, ln_v=17 -> 256 mem_wr with row 16 and mem_din=fb_din
//   pattern, then CLR, then fb_done.
// - lhbl fall during WRITE col 100 -> write completes through col 255 and
//   CLR, then READ starts; no overlap of mem_rd/mem_wr.
// - rst pulse during READ col 50 -> mem_rd=0 in the same cycle; after
//   release, state IDLE and the next lhbl fall restarts at col 0.
// - With VBSKIP_EN, lhbl falls while lvbl=0 -> no mem_rd.
//   Without VBSKIP_EN -> 256 reads.

Source files
------------

// File: rtl/jtframe_lfbuf_memctl.sv
// jtframe_lfbuf_memctl: SDRAM sequencer for the line frame buffer (dump/clear on ln_hs, row fetch on H-blank).
// Optional: JTFRAME_LFBUF_VBSKIP_EN suppresses row fetches during V-blank.
module jtframe_lfbuf_memctl #(
    parameter int          VW   = 8,
    parameter int          HW   = 9,
    parameter logic [HW-1:0] HMAX = 9'd255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VW-1:0]    vrender_i,
    input  logic             lhbl_i,
    input  logic             lvbl_i,
    input  logic             frame_i,
    input  logic             ln_hs_i,
    input  logic [VW-1:0]    ln_v_i,
    output logic [HW-1:0]    fb_addr_o,
    input  logic [15:0]      fb_din_i,
    output logic             fb_clr_o,
    output logic             fb_done_o,
    output logic             line_o,
    output logic [HW-1:0]    rd_addr_o,
    output logic [15:0]      fb_dout_o,
    output logic             scr_we_o,
    output logic [VW+HW:0]   mem_addr_o,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic [15:0]      mem_din_o,
    input  logic [15:0]      mem_dout_i,
    input  logic             mem_ack_i
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, CLR, DONE} state_t;

    state_t          state_q;
    logic            pend_rd_q, pend_wr_q, first_q, hs_q, wait_q, lhbl_q, frame_q, line_q;
    logic [VW-1:0]   row_l_q;
    logic [HW-1:0]   col_q, fb_addr_q, rd_addr_q;
    logic            fb_clr_q, fb_done_q, scr_we_q, mem_rd_q, mem_wr_q;
    logic [15:0]     fb_dout_q, mem_din_q;
    logic [VW+HW:0]  mem_addr_q;
    logic            rd_set, hs_acc, last;
    logic [HW-1:0]   col_d;

`ifdef JTFRAME_LFBUF_VBSKIP_EN
    assign rd_set = lhbl_q & ~lhbl_i & lvbl_i;
`else
    logic unused_lvbl;
    assign unused_lvbl = lvbl_i;
    assign rd_set = lhbl_q & ~lhbl_i;
`endif
    // a second ln_hs before the dump of the previous one is accepted is dropped
    assign hs_acc = ln_hs_i & ~pend_wr_q & ~hs_q;
    assign last   = col_q == HMAX;
    assign col_d  = col_q + HW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_rd_q  <= 1'b0;
            pend_wr_q  <= 1'b0;
            first_q    <= 1'b1;
            hs_q       <= 1'b0;
            wait_q     <= 1'b0;
            lhbl_q     <= 1'b0;
            frame_q    <= 1'b0;
            line_q     <= 1'b0;
            row_l_q    <= '0;
            col_q      <= '0;
            fb_addr_q  <= '0;
            rd_addr_q  <= '0;
            fb_clr_q   <= 1'b0;
            fb_done_q  <= 1'b0;
            scr_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            fb_dout_q  <= '0;
            mem_din_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            lhbl_q    <= lhbl_i;
            frame_q   <= frame_i;
            hs_q      <= hs_acc;
            scr_we_q  <= 1'b0;
            fb_done_q <= 1'b0;
            if (hs_acc) line_q <= ~line_q;
            if (hs_q) pend_wr_q <= 1'b1;
            case (state_q)
                IDLE: if (pend_rd_q) begin
                    state_q    <= READ;
                    col_q      <= '0;
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= {~frame_i, vrender_i, {HW{1'b0}}};
                end else if (pend_wr_q) begin
                    state_q   <= first_q ? CLR : WRITE;
                    fb_clr_q  <= first_q;
                    col_q     <= '0;
                    fb_addr_q <= '0;
                    wait_q    <= 1'b0;
                end
                READ: if (mem_ack_i) begin
                    fb_dout_q <= mem_dout_i;
                    rd_addr_q <= col_q;
                    scr_we_q  <= 1'b1;
                    if (last) begin
                        mem_rd_q  <= 1'b0;
                        pend_rd_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        col_q      <= col_d;
                        mem_addr_q <= {~frame_i, vrender_i, col_d};
                    end
                end
                // fb_din trails fb_addr by a cycle, so each word waits before requesting
                WRITE: if (mem_wr_q) begin
                    if (mem_ack_i) begin
                        mem_wr_q  <= 1'b0;
                        wait_q    <= 1'b0;
                        col_q     <= last ? '0 : col_d;
                        fb_addr_q <= last ? '0 : col_d;
                        fb_clr_q  <= last;
                        if (last) state_q <= CLR;
                    end
                end else if (wait_q) begin
                    mem_wr_q   <= 1'b1;
                    mem_din_q  <= fb_din_i;
                    mem_addr_q <= {frame_i, row_l_q, col_q};
                    wait_q     <= 1'b0;
                end else begin
                    wait_q <= 1'b1;
                end
                CLR: if (last) begin
                    fb_clr_q  <= 1'b0;
                    fb_done_q <= 1'b1;
                    state_q   <= DONE;
                end else begin
                    col_q     <= col_d;
                    fb_addr_q <= col_d;
                end
                DONE: begin
                    pend_wr_q <= 1'b0;
                    first_q   <= 1'b0;
                    row_l_q   <= ln_v_i;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // new events win over the clears done by the state machine above
            if (rd_set) pend_rd_q <= 1'b1;
            if (frame_q != frame_i) first_q <= 1'b1;
        end
    end

    assign fb_addr_o  = fb_addr_q;
    assign fb_clr_o   = fb_clr_q;
    assign fb_done_o  = fb_done_q;
    assign line_o     = line_q;
    assign rd_addr_o  = rd_addr_q;
    assign fb_dout_o  = fb_dout_q;
    assign scr_we_o   = scr_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_rd_o   = mem_rd_q;
    assign mem_wr_o   = mem_wr_q;
    assign mem_din_o  = mem_din_q;
endmodule

// File: tb/tb_jtframe_lfbuf_memctl.sv
// tb_jtframe_lfbuf_memctl: directed scenarios with a per-cycle scoreboard of the SDRAM and line-buffer traffic.
module tb_jtframe_lfbuf_memctl;
    localparam int AW = 18;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] vrender = 8'd5, ln_v = 8'd0;
    logic lhbl = 1'b1, lvbl = 1'b1, frame = 1'b0, ln_hs = 1'b0;
    logic [8:0] fb_addr, rd_addr;
    logic [15:0] fb_din = 16'd0, fb_dout, mem_din, mem_dout = 16'd0;
    logic fb_clr, fb_done, line, scr_we, mem_rd, mem_wr, mem_ack = 1'b0;
    logic [AW-1:0] mem_addr;

    jtframe_lfbuf_memctl dut (
        .clk(clk), .rst(rst), .vrender_i(vrender), .lhbl_i(lhbl), .lvbl_i(lvbl),
        .frame_i(frame), .ln_hs_i(ln_hs), .ln_v_i(ln_v), .fb_addr_o(fb_addr),
        .fb_din_i(fb_din), .fb_clr_o(fb_clr), .fb_done_o(fb_done), .line_o(line),
        .rd_addr_o(rd_addr), .fb_dout_o(fb_dout), .scr_we_o(scr_we),
        .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
        .mem_din_o(mem_din), .mem_dout_i(mem_dout), .mem_ack_i(mem_ack)
    );

    always #5 clk = ~clk;

    int vec = 0, errs = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] memf(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction
    function automatic logic [15:0] fbf(input logic [8:0] a);
        return 16'({7'd0, a} * 16'd3) ^ 16'h1234;
    endfunction

    // SDRAM: acks one cycle after a request is seen; line buffer: registered read
    always @(posedge clk) begin
        if (rst) mem_ack <= 1'b0;
        else if ((mem_rd | mem_wr) && !mem_ack) begin
            mem_ack  <= 1'b1;
            mem_dout <= memf(mem_addr);
        end else mem_ack <= 1'b0;
        fb_din <= fbf(fb_addr);
    end

    int rd_tot = 0, sw_tot = 0, wr_tot = 0, clr_tot = 0, done_tot = 0;
    logic [7:0] rd_col = 0, sw_col = 0, wr_col = 0, clr_col = 0, row_exp = 0;
    logic busy = 0, prev_req = 0, prev_rd = 0;
    logic [AW-1:0] prev_addr = 0;
    logic [15:0] prev_din = 0;

    always @(negedge clk) begin
        if (rst) begin
            rd_col = 0; sw_col = 0; wr_col = 0; clr_col = 0; busy = 0; prev_req = 0;
        end else begin
            if (mem_rd || mem_wr) chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
            if (prev_req) begin
                chk("req_hold_strobe", 32'({mem_rd, mem_wr}), 32'({prev_rd, ~prev_rd}));
                chk("req_hold_addr", 32'(mem_addr), 32'(prev_addr));
                if (!prev_rd) chk("req_hold_din", 32'(mem_din), 32'(prev_din));
            end
            if (mem_rd) chk("rd_during_dump", 32'(busy), 32'd0);
            if (mem_rd && mem_ack) begin
                chk("rd_req_addr", 32'(mem_addr), 32'({~frame, vrender, 1'b0, rd_col}));
                rd_col++; rd_tot++;
            end
            if (scr_we) begin
                chk("scr_rd_addr", 32'(rd_addr), 32'({1'b0, sw_col}));
                chk("scr_data", 32'(fb_dout), 32'(memf({~frame, vrender, 1'b0, sw_col})));
                sw_col++; sw_tot++;
            end
            if (mem_wr && mem_ack) begin
                chk("wr_req_addr", 32'(mem_addr), 32'({frame, row_exp, 1'b0, wr_col}));
                chk("wr_data", 32'(mem_din), 32'(fbf({1'b0, wr_col})));
                wr_col++; wr_tot++;
            end
            if (fb_clr) begin
                chk("clr_addr", 32'(fb_addr), 32'({1'b0, clr_col}));
                clr_col++; clr_tot++;
            end
            if (mem_wr || fb_clr) busy = 1;
            if (fb_done) begin busy = 0; done_tot++; end
            prev_req  = (mem_rd || mem_wr) && !mem_ack;
            prev_rd   = mem_rd;
            prev_addr = mem_addr;
            prev_din  = mem_din;
        end
    end

    function automatic int cnt(input int sel);
        return sel == 0 ? rd_tot : sel == 1 ? sw_tot : sel == 2 ? wr_tot : sel == 3 ? clr_tot : done_tot;
    endfunction

    task automatic wait_for(input string nm, input int sel, input int target, input int budget);
        int n = 0;
        while (cnt(sel) < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(nm, 32'(cnt(sel)), 32'(target));
    endtask

    task automatic lhbl_fall();
        @(posedge clk); #1 lhbl = 1'b0;
        repeat (3) @(posedge clk);
        #1 lhbl = 1'b1;
    endtask

    task automatic pulse_hs();
        @(posedge clk); #1 ln_hs = 1'b1;
        @(posedge clk); #1 ln_hs = 1'b0;
    endtask

    int br, bs, bw, bc, bd;
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem", 32'({mem_rd, mem_wr, mem_addr}), 32'd0);
        chk("rst_fb", 32'({fb_clr, fb_done, line, scr_we, fb_addr, rd_addr}), 32'd0);
        chk("rst_data", {mem_din, fb_dout}, 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        // row fetch from page ~frame
        br = rd_tot; bs = sw_tot; bw = wr_tot;
        lhbl_fall();
        wait_for("s1_reads", 0, br + 256, 2000);
        wait_for("s1_scr_we", 1, bs + 256, 50);
        repeat (10) @(posedge clk);
        chk("s1_rd_count", 32'(rd_tot - br), 32'd256);
        chk("s1_last_rd_addr", 32'(rd_addr), 32'd255);
        chk("s1_last_dout", 32'(fb_dout), 32'h0000AF3C);
        chk("s1_no_writes", 32'(wr_tot - bw), 32'd0);
        // first line after a page change: clear only
        @(posedge clk); #1 frame = 1'b1;
        repeat (4) @(posedge clk);
        ln_v = 8'd16; bw = wr_tot; bc = clr_tot; bd = done_tot;
        pulse_hs();
        chk("s2_line", 32'(line), 32'd1);
        wait_for("s2_done", 4, bd + 1, 2000);
        repeat (10) @(posedge clk);
        chk("s2_no_writes", 32'(wr_tot - bw), 32'd0);
        chk("s2_clr_count", 32'(clr_tot - bc), 32'd256);
        chk("s2_done_count", 32'(done_tot - bd), 32'd1);
        row_exp = 8'd16;
        // dump of row 16, then clear
        ln_v = 8'd17; bw = wr_tot; bc = clr_tot; bd = done_tot;
        pulse_hs();
        chk("s3_line", 32'(line), 32'd0);
        wait_for("s3_done", 4, bd + 1, 3000);
        repeat (10) @(posedge clk);
        chk("s3_wr_count", 32'(wr_tot - bw), 32'd256);
        chk("s3_clr_count", 32'(clr_tot - bc), 32'd256);
        chk("s3_done_count", 32'(done_tot - bd), 32'd1);
        chk("s3_last_wr_addr", 32'(mem_addr), 32'h000220FF);
        chk("s3_last_wr_din", 32'(mem_din), 32'h000010C9);
        row_exp = 8'd17;
        // fetch requested mid-dump waits for write+clear; extra ln_hs is dropped
        ln_v = 8'd18; br = rd_tot; bw = wr_tot; bc = clr_tot; bd = done_tot;
        pulse_hs();
        chk("s4_line", 32'(line), 32'd1);
        wait_for("s4_wr100", 2, bw + 100, 1000);
        lhbl_fall();
        pulse_hs();
        chk("s4_hs_dropped", 32'(line), 32'd1);
        wait_for("s4_done", 4, bd + 1, 3000);
        wait_for("s4_reads", 0, br + 256, 2000);
        repeat (10) @(posedge clk);
        chk("s4_wr_count", 32'(wr_tot - bw), 32'd256);
        chk("s4_clr_count", 32'(clr_tot - bc), 32'd256);
        chk("s4_rd_count", 32'(rd_tot - br), 32'd256);
        chk("s4_done_count", 32'(done_tot - bd), 32'd1);
        row_exp = 8'd18;
        // reset in the middle of a fetch
        br = rd_tot;
        lhbl_fall();
        wait_for("s5_rd50", 0, br + 50, 500);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("s5_rst_line", 32'(line), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("s5_idle_no_rd", 32'(mem_rd), 32'd0);
        br = rd_tot; bs = sw_tot;
        lhbl_fall();
        wait_for("s5_reads", 0, br + 256, 2000);
        wait_for("s5_scr_we", 1, bs + 256, 50);
        repeat (5) @(posedge clk);
        chk("s5_last_rd_addr", 32'(rd_addr), 32'd255);
        // H-blank during V-blank
        #1 lvbl = 1'b0;
        br = rd_tot;
        lhbl_fall();
        repeat (1200) @(posedge clk);
`ifdef JTFRAME_LFBUF_VBSKIP_EN
        chk("s6_vblank_reads", 32'(rd_tot - br), 32'd0);
`else
        chk("s6_vblank_reads", 32'(rd_tot - br), 32'd256);
`endif
        #1 lvbl = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
